// File: rtl/wav_pkg.sv
// Shared types for the multi-channel scope overlay.
// FSM states and trigger-mode encodings.
package wav_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE,
    STOPPED
  } state_t;

  localparam logic [1:0] TRIG_FREE   = 2'd0;
  localparam logic [1:0] TRIG_RISE   = 2'd1;
  localparam logic [1:0] TRIG_FALL   = 2'd2;
  localparam logic [1:0] TRIG_SINGLE = 2'd3;

endpackage

// File: rtl/wav_bank_ram.sv
// Two-bank sample store, one write and one read port.
// Address MSB selects the bank; read data is registered.
module wav_bank_ram #(
  parameter int W  = 16,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/wav_scope_overlay.sv
// Triggered multi-channel waveform capture with a
// double-buffered, tear-free overlay on the video stream.
module wav_scope_overlay
  import wav_pkg::*;
#(
  parameter int CH      = 2,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 1024,
  parameter int H_START = 442,
  parameter int V_START = 9,
  parameter int WIN_W   = 1024,
  parameter int WIN_H   = 1024,
  parameter int Y_SHIFT = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int TW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               samp_valid,
  input  logic [CH*DATA_W-1:0] samp_data,
  input  logic [1:0]         trig_mode,
  input  logic [TW-1:0]      trig_ch,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic [7:0]         dec,
  input  logic               arm,
  input  logic               line_mode,
  input  logic [CH*24-1:0]   wave_color,
  input  logic               i_hs,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic [23:0]        i_data,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic [23:0]        o_data,
  output logic               cap_done,
  output logic               stopped
);

  localparam int SW = CH * DATA_W;

  state_t state, state_n;
  logic [7:0] dcnt;
  logic acc;
  logic [SW-1:0] prev;
  logic prev_ok;
  logic [DATA_W-1:0] cur, pv;
  logic rise, fall, trig;
  logic [AW-1:0] waddr, waddr_n, wa;
  logic we;
  logic disp_bank, bank_n;
  logic disp_valid, valid_n;
  logic cap_n, stop_n;
  logic vs_q, de_q, vs_rise, de_fall;

  assign acc = samp_valid && (dcnt == dec);
  assign vs_rise = i_vs && !vs_q;
  assign de_fall = !i_de && de_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      dcnt    <= '0;
      prev    <= '0;
      prev_ok <= 1'b0;
    end else begin
      if (samp_valid) begin
        dcnt <= acc ? '0 : dcnt + 8'd1;
      end
      if (acc) begin
        prev    <= samp_data;
        prev_ok <= 1'b1;
      end
    end
  end

  always_comb begin
    cur = '0;
    pv  = '0;
    for (int c = 0; c < CH; c++) begin
      if (trig_ch == TW'(c)) begin
        cur = samp_data[c*DATA_W +: DATA_W];
        pv  = prev[c*DATA_W +: DATA_W];
      end
    end
  end

  assign rise = prev_ok && (pv < trig_level)
             && (cur >= trig_level);
  assign fall = prev_ok && (pv >= trig_level)
             && (cur < trig_level);

  always_comb begin
    trig = 1'b1;
    unique case (trig_mode)
      TRIG_FREE:   trig = 1'b1;
      TRIG_RISE:   trig = rise;
      TRIG_FALL:   trig = fall;
      TRIG_SINGLE: trig = rise;
    endcase
  end

  always_comb begin
    state_n = state;
    waddr_n = waddr;
    wa      = waddr;
    we      = 1'b0;
    bank_n  = disp_bank;
    valid_n = disp_valid;
    cap_n   = cap_done;
    stop_n  = stopped;
    unique case (state)
      IDLE: state_n = ARMED;
      ARMED: begin
        if (acc && trig) begin
          we      = 1'b1;
          wa      = '0;
          waddr_n = AW'(1);
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (acc) begin
          we      = 1'b1;
          waddr_n = waddr + AW'(1);
          if (waddr == AW'(DEPTH - 1)) begin
            state_n = DONE;
            cap_n   = 1'b1;
          end
        end
      end
      DONE: begin
        if (vs_rise) begin
          bank_n  = ~disp_bank;
          valid_n = 1'b1;
          cap_n   = 1'b0;
          if (trig_mode == TRIG_SINGLE) begin
            state_n = STOPPED;
            stop_n  = 1'b1;
          end else begin
            state_n = ARMED;
          end
        end
      end
      STOPPED: begin
        if (arm) begin
          stop_n  = 1'b0;
          state_n = ARMED;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      waddr      <= '0;
      disp_bank  <= 1'b0;
      disp_valid <= 1'b0;
      cap_done   <= 1'b0;
      stopped    <= 1'b0;
    end else begin
      state      <= state_n;
      waddr      <= waddr_n;
      disp_bank  <= bank_n;
      disp_valid <= valid_n;
      cap_done   <= cap_n;
      stopped    <= stop_n;
    end
  end

  logic [11:0] x, y, dx, dy, rb;
  logic inw;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      vs_q <= i_vs;
      de_q <= i_de;
      if (i_de) begin
        x <= x + 12'd1;
      end else if (de_fall) begin
        x <= '0;
      end
      if (vs_rise) begin
        y <= '0;
      end else if (de_fall) begin
        y <= y + 12'd1;
      end
    end
  end

  assign dx = x - 12'(H_START);
  assign dy = y - 12'(V_START);
  assign rb = (12'(WIN_H - 1) - dy) >> Y_SHIFT;
  assign inw = i_de
            && x >= 12'(H_START)
            && x <= 12'(H_START + WIN_W - 1)
            && y >= 12'(V_START)
            && y <= 12'(V_START + WIN_H - 1);

  logic hs1, vs1, de1, win1, first1;
  logic hs2, vs2, de2, win2, first2;
  logic [23:0] d1, d2;
  logic [11:0] rb1, rb2;
  logic [AW:0] raddr1;
  logic [SW-1:0] rdata, rprev;

  wav_bank_ram #(
    .W  (SW),
    .AW (AW + 1)
  ) u_ram (
    .clk   (pclk),
    .we    (we),
    .waddr ({~disp_bank, wa}),
    .wdata (samp_data),
    .raddr (raddr1),
    .rdata (rdata)
  );

  logic [11:0] s, sp, lo, hi;
  logic hit;
  logic [23:0] pix;

  // Descending scan so the lowest-index hit wins.
  always_comb begin
    pix = d2;
    s   = '0;
    sp  = '0;
    lo  = '0;
    hi  = '0;
    hit = 1'b0;
    for (int c = CH - 1; c >= 0; c--) begin
      s  = 12'(rdata[c*DATA_W +: DATA_W]);
      sp = first2 ? s
         : 12'(rprev[c*DATA_W +: DATA_W]);
      lo = (s < sp) ? s : sp;
      hi = (s < sp) ? sp : s;
      hit = line_mode ? (rb2 >= lo && rb2 <= hi)
                      : (rb2 == s);
      if (win2 && hit) begin
        pix = wave_color[c*24 +: 24];
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      {hs1, vs1, de1, win1, first1} <= '0;
      {hs2, vs2, de2, win2, first2} <= '0;
      d1     <= '0;
      d2     <= '0;
      rb1    <= '0;
      rb2    <= '0;
      raddr1 <= '0;
      rprev  <= '0;
      o_hs   <= 1'b0;
      o_vs   <= 1'b0;
      o_de   <= 1'b0;
      o_data <= '0;
    end else begin
      hs1    <= i_hs;
      vs1    <= i_vs;
      de1    <= i_de;
      d1     <= i_data;
      win1   <= inw && disp_valid;
      first1 <= (dx == 12'd0);
      rb1    <= rb;
      raddr1 <= {disp_bank, dx[AW-1:0]};
      hs2    <= hs1;
      vs2    <= vs1;
      de2    <= de1;
      d2     <= d1;
      win2   <= win1;
      first2 <= first1;
      rb2    <= rb1;
      rprev  <= rdata;
      o_hs   <= hs2;
      o_vs   <= vs2;
      o_de   <= de2;
      o_data <= pix;
    end
  end

endmodule
